// File: rtl/smi_frame_arbiter_wrr_x4.sv
`default_nettype none
// ============================================================================
// Module   : smi_frame_arbiter_wrr_x4
// Brief    : Weighted round-robin frame arbiter, four SMI inputs onto one SMI
//            output. Whole frames only, zero-wait switching at frame ends.
// Revision : 1.0
// ============================================================================
module smi_frame_arbiter_wrr_x4 #(
  parameter int         FlitWidth   = 2,
  parameter logic [7:0] EofcMask    = 8'(2*FlitWidth-1),
  parameter int         WeightWidth = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   smiInAReady,
  input  logic                   smiInBReady,
  input  logic                   smiInCReady,
  input  logic                   smiInDReady,
  input  logic [7:0]             smiInAEofc,
  input  logic [7:0]             smiInBEofc,
  input  logic [7:0]             smiInCEofc,
  input  logic [7:0]             smiInDEofc,
  input  logic [FlitWidth*8-1:0] smiInAData,
  input  logic [FlitWidth*8-1:0] smiInBData,
  input  logic [FlitWidth*8-1:0] smiInCData,
  input  logic [FlitWidth*8-1:0] smiInDData,
  output logic                   smiInAStop,
  output logic                   smiInBStop,
  output logic                   smiInCStop,
  output logic                   smiInDStop,
  input  logic [WeightWidth-1:0] weightA,
  input  logic [WeightWidth-1:0] weightB,
  input  logic [WeightWidth-1:0] weightC,
  input  logic [WeightWidth-1:0] weightD,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop,
  output logic                   grantActive,
  output logic [1:0]             grantPort
);

  localparam int         c_DataW = FlitWidth*8;
  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_XFER  = 1'b1;

  logic [3:0]             w_rawReady;
  logic [7:0]             w_rawEofc [4];
  logic [c_DataW-1:0]     w_rawData [4];
  logic [WeightWidth-1:0] w_weight  [4];

  assign w_rawReady   = {smiInDReady, smiInCReady, smiInBReady, smiInAReady};
  assign w_rawEofc[0] = smiInAEofc;
  assign w_rawEofc[1] = smiInBEofc;
  assign w_rawEofc[2] = smiInCEofc;
  assign w_rawEofc[3] = smiInDEofc;
  assign w_rawData[0] = smiInAData;
  assign w_rawData[1] = smiInBData;
  assign w_rawData[2] = smiInCData;
  assign w_rawData[3] = smiInDData;
  assign w_weight[0]  = weightA;
  assign w_weight[1]  = weightB;
  assign w_weight[2]  = weightC;
  assign w_weight[3]  = weightD;

  logic [0:0]             r_state;
  logic [1:0]             r_grant;
  logic [1:0]             r_ptr;
  logic [WeightWidth-1:0] r_credit;

  logic [3:0]             r_rdy;
  logic [3:0]             r_last;
  logic [7:0]             r_eofc [4];
  logic [c_DataW-1:0]     r_data [4];
  logic [3:0]             w_halt;
  logic [3:0]             w_stop;

  logic [1:0]             r_count;
  logic                   r_outValid;
  logic                   r_wrPtr;
  logic                   r_rdPtr;
  logic [c_DataW-1:0]     r_bufData [2];
  logic [7:0]             r_bufEofc [2];
  logic                   w_bufFull;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_lastPush;
  logic [1:0]             w_countNext;

  // Only the granted port may drain into the output buffer; everyone else waits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_halt[i] = 1'b1;
      if (r_state == c_XFER && r_grant == 2'(i)) w_halt[i] = w_bufFull;
    end
  end

  assign w_stop     = r_rdy & w_halt;
  assign smiInAStop = w_stop[0];
  assign smiInBStop = w_stop[1];
  assign smiInCStop = w_stop[2];
  assign smiInDStop = w_stop[3];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdy <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!w_stop[i]) r_rdy[i] <= w_rawReady[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!w_stop[i] && w_rawReady[i]) begin
        r_last[i] <= |w_rawEofc[i];
        r_eofc[i] <= w_rawEofc[i] & EofcMask;
        r_data[i] <= w_rawData[i];
      end
    end
  end

  // Cyclic search starting at 'start'; result is {found, index}.
  function automatic logic [2:0] f_search(input logic [3:0] elig, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (elig[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [3:0] w_nz;
  logic [3:0] w_eligIdle;
  logic [3:0] w_eligXfer;
  logic [2:0] w_idleSel;
  logic [2:0] w_xferSel;

  always_comb begin
    for (int i = 0; i < 4; i++) w_nz[i] = |w_weight[i];
  end

  assign w_eligIdle = r_rdy & w_nz;

  // The granted port's register is being emptied, so its next-cycle content is the raw input.
  always_comb begin
    w_eligXfer          = r_rdy & w_nz;
    w_eligXfer[r_grant] = w_rawReady[r_grant] & w_nz[r_grant];
  end

  assign w_idleSel = f_search(w_eligIdle, r_ptr + 2'd1);
  assign w_xferSel = f_search(w_eligXfer, r_grant + 2'd1);

  assign w_bufFull   = (r_count == 2'd2);
  assign w_push      = (r_state == c_XFER) && r_rdy[r_grant] && !w_bufFull;
  assign w_lastPush  = w_push && r_last[r_grant];
  assign w_pop       = r_outValid && !smiOutStop;
  assign w_countNext = r_count + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= c_IDLE;
      r_grant  <= 2'd0;
      r_ptr    <= 2'd3;
      r_credit <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_idleSel[2]) begin
            r_state  <= c_XFER;
            r_grant  <= w_idleSel[1:0];
            r_ptr    <= w_idleSel[1:0];
            r_credit <= w_weight[w_idleSel[1:0]];
          end
        end
        c_XFER: begin
          if (w_lastPush) begin
            if ((r_credit - WeightWidth'(1)) != '0 && w_rawReady[r_grant]) begin
              r_credit <= r_credit - WeightWidth'(1);
            end else if (w_xferSel[2]) begin
              r_grant  <= w_xferSel[1:0];
              r_ptr    <= w_xferSel[1:0];
              r_credit <= w_weight[w_xferSel[1:0]];
            end else begin
              r_state <= c_IDLE;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count    <= 2'd0;
      r_outValid <= 1'b0;
      r_wrPtr    <= 1'b0;
      r_rdPtr    <= 1'b0;
    end else begin
      r_count    <= w_countNext;
      r_outValid <= (w_countNext != 2'd0);
      if (w_push) r_wrPtr <= ~r_wrPtr;
      if (w_pop)  r_rdPtr <= ~r_rdPtr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_bufData[r_wrPtr] <= r_data[r_grant];
      r_bufEofc[r_wrPtr] <= r_eofc[r_grant];
    end
  end

  assign smiOutReady = r_outValid;
  assign smiOutData  = r_bufData[r_rdPtr];
  assign smiOutEofc  = r_bufEofc[r_rdPtr];
  assign grantActive = (r_state == c_XFER);
  assign grantPort   = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_smi_frame_arbiter_wrr_x4.sv
`default_nettype none
// ============================================================================
// Module   : tb_smi_frame_arbiter_wrr_x4
// Brief    : Self-checking bench; frame-level WRR model plus flit scoreboard.
// Revision : 1.0
// ============================================================================
module tb_smi_frame_arbiter_wrr_x4;

  localparam int         FW   = 2;
  localparam int         DW   = FW*8;
  localparam logic [7:0] MASK = 8'(2*FW-1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [7:0]    eofc;
    logic          last;
  } flit_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [3:0]    inRdy;
  logic [7:0]    inEofc [4];
  logic [DW-1:0] inData [4];
  logic [3:0]    inStop;
  logic [3:0]    weight [4];
  logic          outReady;
  logic [7:0]    outEofc;
  logic [DW-1:0] outData;
  logic          outStop;
  logic          grantActive;
  logic [1:0]    grantPort;

  always #5 clk = ~clk;

  smi_frame_arbiter_wrr_x4 #(.FlitWidth(FW), .EofcMask(MASK), .WeightWidth(4)) dut (
    .clk(clk), .rstn(rstn),
    .smiInAReady(inRdy[0]), .smiInBReady(inRdy[1]), .smiInCReady(inRdy[2]), .smiInDReady(inRdy[3]),
    .smiInAEofc(inEofc[0]), .smiInBEofc(inEofc[1]), .smiInCEofc(inEofc[2]), .smiInDEofc(inEofc[3]),
    .smiInAData(inData[0]), .smiInBData(inData[1]), .smiInCData(inData[2]), .smiInDData(inData[3]),
    .smiInAStop(inStop[0]), .smiInBStop(inStop[1]), .smiInCStop(inStop[2]), .smiInDStop(inStop[3]),
    .weightA(weight[0]), .weightB(weight[1]), .weightC(weight[2]), .weightD(weight[3]),
    .smiOutReady(outReady), .smiOutEofc(outEofc), .smiOutData(outData), .smiOutStop(outStop),
    .grantActive(grantActive), .grantPort(grantPort)
  );

  flit_t srcQ [4][$];
  flit_t expQ [4][$];
  int    expSeq [$];
  int    gpSeen [$];
  int    wt [4];
  int    nf [4];
  int    vectors = 0;
  int    miscompares = 0;
  int    stepNo = 0;
  int    stopPct = 0;
  int    outCount, firstOutStep, lastOutStep, firstAccStep, frameIdx, curPort, cGranted;
  bit    inFrame;
  bit    prevActive;
  logic [1:0] prevGp;
  logic [3:0] srcEn;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      if (srcEn[p] && srcQ[p].size() > 0) begin
        inRdy[p]  = 1'b1;
        inData[p] = srcQ[p][0].data;
        inEofc[p] = srcQ[p][0].eofc;
      end else begin
        inRdy[p]  = 1'b0;
        inData[p] = DW'($urandom);
        inEofc[p] = 8'($urandom);
      end
    end
    outStop = ($urandom_range(99) < stopPct);
  endtask

  task automatic setWeights();
    for (int p = 0; p < 4; p++) weight[p] = 4'(wt[p]);
  endtask

  // len == 0 selects a random frame length of 1..4 flits.
  task automatic addFrames(input int p, input int n, input int len);
    flit_t f;
    logic [DW-1:0] d;
    int L;
    for (int k = 0; k < n; k++) begin
      L = (len == 0) ? int'($urandom_range(1, 4)) : len;
      for (int i = 0; i < L; i++) begin
        d = DW'($urandom);
        d[DW-1 -: 2] = 2'(p);
        f.data = d;
        f.last = (i == L-1);
        f.eofc = f.last ? 8'($urandom_range(1, 255)) : 8'h00;
        srcQ[p].push_back(f);
      end
    end
  endtask

  // Frame-level WRR: pointer starts at D; each grant gives wt frames; stops where a port runs dry.
  task automatic buildSeq();
    int rem [4];
    int ptr, g, sel;
    bit found;
    expSeq.delete();
    ptr = 3;
    sel = 0;
    for (int p = 0; p < 4; p++) rem[p] = nf[p];
    while (expSeq.size() < 256) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        g = (ptr + k) % 4;
        if (!found && wt[g] > 0 && nf[g] > 0) begin
          found = 1;
          sel = g;
        end
      end
      if (!found) break;
      ptr = sel;
      for (int c = 0; c < wt[sel]; c++) begin
        if (rem[sel] == 0) return;
        expSeq.push_back(sel);
        rem[sel]--;
      end
    end
  endtask

  task automatic monitorFlit();
    int t;
    flit_t e;
    t = int'(outData[DW-1 -: 2]);
    if (!inFrame) begin
      if (frameIdx < expSeq.size()) chk("frameOrder", 32'(t), 32'(expSeq[frameIdx]));
      curPort = t;
      inFrame = 1;
    end else begin
      chk("interleave", 32'(t), 32'(curPort));
    end
    chk("flitPending", 32'(expQ[t].size() != 0), 32'd1);
    if (expQ[t].size() != 0) begin
      e = expQ[t].pop_front();
      chk("data", 32'(outData), 32'(e.data));
      chk("eofc", 32'(outEofc), 32'(e.eofc & MASK));
      if (e.last) begin
        inFrame = 0;
        frameIdx++;
      end
    end
    outCount++;
    if (firstOutStep < 0) firstOutStep = stepNo;
    lastOutStep = stepNo;
  endtask

  task automatic step();
    @(negedge clk);
    stepNo++;
    if (rstn) begin
      for (int p = 0; p < 4; p++) begin
        if (inRdy[p] && !inStop[p]) begin
          expQ[p].push_back(srcQ[p].pop_front());
          if (firstAccStep < 0) firstAccStep = stepNo;
        end
      end
      if (outReady && !outStop) monitorFlit();
      if (grantActive && (!prevActive || grantPort != prevGp)) gpSeen.push_back(int'(grantPort));
      if (grantActive && grantPort == 2'd2) cGranted++;
      prevActive = grantActive;
      prevGp     = grantPort;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit drained(input logic [3:0] mask);
    bit d;
    d = !inFrame;
    for (int p = 0; p < 4; p++)
      if (mask[p] && (srcQ[p].size() != 0 || expQ[p].size() != 0)) d = 0;
    return d;
  endfunction

  task automatic runUntilDrained(input string tag, input logic [3:0] mask, input int limit);
    int n;
    n = 0;
    while (n < limit && !drained(mask)) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 32'(n < limit), 32'd1);
  endtask

  task automatic resetDut();
    rstn = 1'b0;
    srcEn = '0;
    for (int p = 0; p < 4; p++) begin
      srcQ[p].delete();
      expQ[p].delete();
    end
    expSeq.delete();
    gpSeen.delete();
    inFrame = 0;
    frameIdx = 0;
    outCount = 0;
    firstOutStep = -1;
    lastOutStep = -1;
    firstAccStep = -1;
    cGranted = 0;
    prevActive = 0;
    stopPct = 0;
    drive();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic chkGrantEpisodes(input string tag);
    int gm [$];
    foreach (expSeq[i]) if (i == 0 || expSeq[i] != expSeq[i-1]) gm.push_back(expSeq[i]);
    chk({tag, "_grantCount"}, 32'(gpSeen.size()), 32'(gm.size()));
    for (int i = 0; i < gm.size() && i < gpSeen.size(); i++)
      chk({tag, "_grantPort"}, 32'(gpSeen[i]), 32'(gm[i]));
  endtask

  initial begin
    resetDut();

    // Reset state
    chk("rst_outReady", 32'(outReady), 32'd0);
    chk("rst_grantActive", 32'(grantActive), 32'd0);
    chk("rst_grantPort", 32'(grantPort), 32'd0);
    chk("rst_stops", 32'(inStop), 32'd0);

    // Port A alone, weight 1, three 4-flit frames
    resetDut();
    wt = '{1, 0, 0, 0}; nf = '{3, 0, 0, 0};
    setWeights(); buildSeq();
    addFrames(0, 3, 4); srcEn = 4'b0001; drive();
    runUntilDrained("single", 4'b0001, 200);
    chk("single_count", 32'(outCount), 32'd12);
    // Output valid rises two clock edges after the accepting edge.
    chk("single_latency", 32'(firstOutStep - 1 - firstAccStep), 32'd2);
    chk("single_noBubble", 32'(lastOutStep - firstOutStep + 1), 32'd12);

    // A=3, B=1, 2-flit frames
    resetDut();
    wt = '{3, 1, 0, 0}; nf = '{6, 2, 0, 0};
    setWeights(); buildSeq();
    addFrames(0, 6, 2); addFrames(1, 2, 2); srcEn = 4'b0011; drive();
    runUntilDrained("wrr31", 4'b0011, 300);
    chk("wrr31_frames", 32'(frameIdx), 32'd8);
    chk("wrr31_noBubble", 32'(lastOutStep - firstOutStep + 1), 32'd16);
    chkGrantEpisodes("wrr31");

    // All four, weight 1, single-flit frames
    resetDut();
    wt = '{1, 1, 1, 1}; nf = '{3, 3, 3, 3};
    setWeights(); buildSeq();
    for (int p = 0; p < 4; p++) addFrames(p, 3, 1);
    srcEn = 4'b1111; drive();
    runUntilDrained("rr4", 4'b1111, 300);
    chk("rr4_frames", 32'(frameIdx), 32'd12);
    chk("rr4_noBubble", 32'(lastOutStep - firstOutStep + 1), 32'd12);
    chkGrantEpisodes("rr4");

    // A and D, 5-flit frames, 50% output backpressure, random weights
    for (int it = 0; it < 2; it++) begin
      resetDut();
      wt = '{int'($urandom_range(1, 4)), 0, 0, int'($urandom_range(1, 4))};
      nf = '{6, 0, 0, 6};
      setWeights(); buildSeq();
      addFrames(0, 6, 5); addFrames(3, 6, 5);
      srcEn = 4'b1001; stopPct = 50; drive();
      runUntilDrained("stallAD", 4'b1001, 1500);
      chk("stallAD_frames", 32'(frameIdx), 32'd12);
    end

    // Four ports, random weights, random frame lengths, random backpressure
    for (int it = 0; it < 3; it++) begin
      resetDut();
      for (int p = 0; p < 4; p++) begin
        wt[p] = int'($urandom_range(1, 3));
        nf[p] = 4;
      end
      setWeights(); buildSeq();
      for (int p = 0; p < 4; p++) addFrames(p, 4, 0);
      srcEn = 4'b1111; stopPct = int'($urandom_range(0, 60)); drive();
      runUntilDrained("rand4", 4'b1111, 2000);
      chk("rand4_frames", 32'(frameIdx), 32'd16);
    end

    // C ready forever with weight 0
    resetDut();
    wt = '{2, 0, 0, 0}; nf = '{4, 0, 0, 0};
    setWeights(); buildSeq();
    addFrames(0, 4, 3); addFrames(2, 2, 2);
    srcEn = 4'b0101; drive();
    runUntilDrained("wzero", 4'b0001, 300);
    chk("wzero_frames", 32'(frameIdx), 32'd4);
    chk("wzero_cNeverGranted", 32'(cGranted), 32'd0);
    chk("wzero_cStopHeld", 32'(inStop[2]), 32'd1);

    // Reset in the middle of a B frame
    resetDut();
    wt = '{1, 2, 0, 0}; nf = '{0, 2, 0, 0};
    setWeights(); buildSeq();
    addFrames(1, 2, 6); srcEn = 4'b0010; drive();
    repeat (6) step();
    chk("midB_grantActive", 32'(grantActive), 32'd1);
    chk("midB_grantPort", 32'(grantPort), 32'd1);
    rstn = 1'b0;
    #2;
    chk("inRst_outReady", 32'(outReady), 32'd0);
    chk("inRst_grantActive", 32'(grantActive), 32'd0);
    chk("inRst_grantPort", 32'(grantPort), 32'd0);
    chk("inRst_stops", 32'(inStop), 32'd0);
    resetDut();
    wt = '{1, 2, 0, 0}; nf = '{2, 2, 0, 0};
    setWeights(); buildSeq();
    addFrames(0, 2, 3); addFrames(1, 2, 3);
    srcEn = 4'b0011; drive();
    runUntilDrained("postRst", 4'b0011, 300);
    chk("postRst_frames", 32'(frameIdx), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
